// File: rtl/dog_action_ctrl_pkg.sv
// Shared definitions for the toy-dog behaviour controller: state codes as seen
// by the 7-segment action decoder, default timing constants and helpers.
package dog_action_ctrl_pkg;

  // State code equals the action code driven onto decoder inputs {A,B,C}.
  // Codes 3'b110 and 3'b111 are unused and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_EAT   = 3'b001,
    ST_PLAY  = 3'b010,
    ST_HAPPY = 3'b011,
    ST_SLEEP = 3'b100,
    ST_ALERT = 3'b101
  } state_t;

  // Default timing at 50 MHz: 1 s per action, 10 s of inactivity before sleep.
  localparam int DEF_ACT_TICKS  = 50_000_000;
  localparam int DEF_IDLE_TICKS = 500_000_000;
  localparam int DEF_CNT_W      = 32;

  // The dog is busy while performing an action or while alerted.
  function automatic logic is_busy(input state_t s);
    return (s == ST_EAT) || (s == ST_PLAY) || (s == ST_HAPPY) || (s == ST_ALERT);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level input, followed by a third
// register that turns the synchronised level into a one-cycle rise pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchroniser chain; s3 is the previous synchronised level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the value the
      // previous stage held before this edge, giving a true shift register.
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/dog_action_ctrl.sv
// Behaviour controller for the toy dog: synchronises buttons and obstacle
// sensor, runs the action/sleep/alert state machine and its dwell timer.
// The state register drives the action decoder directly as {act_a,act_b,act_c}.
module dog_action_ctrl
  import dog_action_ctrl_pkg::*;
#(
  parameter int ACT_TICKS  = DEF_ACT_TICKS,
  parameter int IDLE_TICKS = DEF_IDLE_TICKS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_feed,
  input  logic btn_play,
  input  logic btn_pet,
  input  logic obstacle,
  output logic act_a,
  output logic act_b,
  output logic act_c,
  output logic busy
);

  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACT_TICKS - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};

  logic press_feed;
  logic press_play;
  logic press_pet;
  logic obstacle_s;
  logic unused_obstacle_rise;

  logic unused_feed_lvl;
  logic unused_play_lvl;
  logic unused_pet_lvl;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;

  sync_edge u_sync_feed (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_feed),
    .lvl  (unused_feed_lvl),
    .rise (press_feed)
  );

  sync_edge u_sync_play (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_play),
    .lvl  (unused_play_lvl),
    .rise (press_play)
  );

  sync_edge u_sync_pet (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_pet),
    .lvl  (unused_pet_lvl),
    .rise (press_pet)
  );

  // The obstacle acts on its level only; its rise pulse is not needed.
  sync_edge u_sync_obstacle (
    .clk  (clk),
    .rst  (rst),
    .din  (obstacle),
    .lvl  (obstacle_s),
    .rise (unused_obstacle_rise)
  );

  // Transition rules in priority order: obstacle, alert exit, then per-state.
  function automatic state_t next_state(
    input state_t           cur,
    input logic [CNT_W-1:0] t,
    input logic             obs,
    input logic             p_feed,
    input logic             p_play,
    input logic             p_pet
  );
    state_t nxt;
    // NOTE: default first, so every path through the case assigns nxt and no
    // latch can be inferred when this logic is flattened into gates.
    nxt = cur;
    if (obs && (cur != ST_ALERT)) begin
      nxt = ST_ALERT;
    end else begin
      case (cur)
        ST_ALERT: begin
          if (!obs) nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (p_feed)           nxt = ST_EAT;
          else if (p_play)      nxt = ST_PLAY;
          else if (p_pet)       nxt = ST_HAPPY;
          else if (t == IDLE_LAST) nxt = ST_SLEEP;
        end
        ST_EAT, ST_PLAY, ST_HAPPY: begin
          if (t == ACT_LAST) nxt = ST_IDLE;
        end
        ST_SLEEP: begin
          if (p_feed || p_play || p_pet) nxt = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
    return nxt;
  endfunction

  assign state_nxt = next_state(state, timer, obstacle_s, press_feed, press_play, press_pet);

  // State, busy flag and dwell timer all update together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      busy  <= is_busy(state_nxt);
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign {act_a, act_b, act_c} = state;

endmodule

// File: tb/tb_dog_action_ctrl.sv
// Self-checking bench for dog_action_ctrl: directed scenarios with fixed
// expectations, then random stimulus, all compared each cycle against a
// behavioural model built from the controller's rules.
module tb_dog_action_ctrl;

  localparam int ACT  = 4;
  localparam int IDLE = 10;
  localparam int CW   = 4;

  localparam logic [2:0] A_IDLE  = 3'b000;
  localparam logic [2:0] A_EAT   = 3'b001;
  localparam logic [2:0] A_PLAY  = 3'b010;
  localparam logic [2:0] A_HAPPY = 3'b011;
  localparam logic [2:0] A_SLEEP = 3'b100;
  localparam logic [2:0] A_ALERT = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_feed = 1'b0;
  logic btn_play = 1'b0;
  logic btn_pet = 1'b0;
  logic obstacle = 1'b0;
  logic act_a, act_b, act_c, busy;
  logic [2:0] act;

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dog_action_ctrl #(
    .ACT_TICKS (ACT),
    .IDLE_TICKS(IDLE),
    .CNT_W     (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_feed(btn_feed),
    .btn_play(btn_play),
    .btn_pet (btn_pet),
    .obstacle(obstacle),
    .act_a   (act_a),
    .act_b   (act_b),
    .act_c   (act_c),
    .busy    (busy)
  );

  assign act = {act_a, act_b, act_c};

  // Reference model: raw input history per edge (bit0 = newest sample), the
  // current behaviour and how many cycles it has lasted.
  logic [2:0] h_feed = '0, h_play = '0, h_pet = '0, h_obs = '0;
  logic [2:0] m_act = A_IDLE;
  int         m_dwell = 0;

  function automatic logic m_busy(input logic [2:0] a);
    return (a == A_EAT) || (a == A_PLAY) || (a == A_HAPPY) || (a == A_ALERT);
  endfunction

  always @(posedge clk) begin
    logic       pf, pp, pt, ob;
    logic [2:0] nx;
    if (rst) begin
      m_act = A_IDLE; m_dwell = 0;
      h_feed = '0; h_play = '0; h_pet = '0; h_obs = '0;
    end else begin
      // A level seen two edges ago and absent three edges ago is a press now.
      pf = h_feed[1] & ~h_feed[2];
      pp = h_play[1] & ~h_play[2];
      pt = h_pet[1]  & ~h_pet[2];
      ob = h_obs[1];
      nx = m_act;
      if (ob && m_act != A_ALERT) nx = A_ALERT;
      else if (m_act == A_ALERT) begin
        if (!ob) nx = A_IDLE;
      end else if (m_act == A_IDLE) begin
        if (pf) nx = A_EAT;
        else if (pp) nx = A_PLAY;
        else if (pt) nx = A_HAPPY;
        else if (m_dwell + 1 == IDLE) nx = A_SLEEP;
      end else if (m_act == A_SLEEP) begin
        if (pf || pp || pt) nx = A_IDLE;
      end else if (m_dwell + 1 == ACT) nx = A_IDLE;
      m_dwell = (nx != m_act) ? 0 : m_dwell + 1;
      m_act   = nx;
      h_feed = {h_feed[1:0], btn_feed};
      h_play = {h_play[1:0], btn_play};
      h_pet  = {h_pet[1:0],  btn_pet};
      h_obs  = {h_obs[1:0],  obstacle};
    end
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_eval++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock, then compare the DUT against the model away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("model_act",  {1'b0, act},  {1'b0, m_act});
    check("model_busy", {3'b0, busy}, {3'b0, m_busy(m_act)});
  endtask

  initial begin
    // Reset then idle into sleep.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_act",  {1'b0, act}, {1'b0, A_IDLE});
    check("rst_busy", {3'b0, busy}, 4'd0);
    for (int i = 1; i < IDLE; i++) begin
      tick();
      check("idle_wait", {1'b0, act}, {1'b0, A_IDLE});
    end
    tick();
    check("sleep_entry", {1'b0, act}, {1'b0, A_SLEEP});
    check("sleep_busy",  {3'b0, busy}, 4'd0);

    // First press in sleep only wakes the dog.
    btn_pet = 1'b1;
    tick(); tick();
    check("sleep_hold", {1'b0, act}, {1'b0, A_SLEEP});
    tick();
    check("wake_idle", {1'b0, act}, {1'b0, A_IDLE});
    btn_pet = 1'b0;
    tick(); tick();
    check("wake_stays_idle", {1'b0, act}, {1'b0, A_IDLE});

    // Second press starts feeding two edges after it is seen.
    btn_feed = 1'b1;
    tick(); tick();
    check("feed_latency", {1'b0, act}, {1'b0, A_IDLE});
    tick();
    check("feed_start", {1'b0, act}, {1'b0, A_EAT});
    check("feed_busy",  {3'b0, busy}, 4'd1);
    btn_feed = 1'b0;
    tick();
    check("eat_1", {1'b0, act}, {1'b0, A_EAT});
    btn_pet = 1'b1;
    tick();
    check("eat_2", {1'b0, act}, {1'b0, A_EAT});
    btn_pet = 1'b0;
    tick();
    check("eat_3", {1'b0, act}, {1'b0, A_EAT});
    tick();
    check("eat_end",      {1'b0, act}, {1'b0, A_IDLE});
    check("eat_end_busy", {3'b0, busy}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pet_ignored", {1'b0, act}, {1'b0, A_IDLE});
    end

    // Simultaneous play and pet: play wins, pet is dropped.
    btn_play = 1'b1; btn_pet = 1'b1;
    tick(); tick(); tick();
    check("sim_play", {1'b0, act}, {1'b0, A_PLAY});
    for (int i = 1; i < ACT; i++) begin
      tick();
      check("sim_play_hold", {1'b0, act}, {1'b0, A_PLAY});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sim_no_happy", {1'b0, act}, {1'b0, A_IDLE});
    end
    btn_play = 1'b0; btn_pet = 1'b0;
    tick();

    // Obstacle during play, feed press while alerted is dropped.
    btn_play = 1'b1;
    tick(); tick(); tick();
    check("play_start", {1'b0, act}, {1'b0, A_PLAY});
    btn_play = 1'b0;
    tick();
    obstacle = 1'b1;
    tick(); tick();
    check("play_before_alert", {1'b0, act}, {1'b0, A_PLAY});
    tick();
    check("alert_entry", {1'b0, act}, {1'b0, A_ALERT});
    check("alert_busy",  {3'b0, busy}, 4'd1);
    tick();
    btn_feed = 1'b1;
    tick();
    btn_feed = 1'b0;
    tick();
    obstacle = 1'b0;
    tick(); tick();
    check("alert_hold", {1'b0, act}, {1'b0, A_ALERT});
    tick();
    check("alert_exit",      {1'b0, act}, {1'b0, A_IDLE});
    check("alert_exit_busy", {3'b0, busy}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("feed_dropped", {1'b0, act}, {1'b0, A_IDLE});
    end

    // Reset in the middle of HAPPY.
    btn_pet = 1'b1;
    tick(); tick(); tick();
    check("happy_start", {1'b0, act}, {1'b0, A_HAPPY});
    btn_pet = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_act",  {1'b0, act}, {1'b0, A_IDLE});
    check("rst_mid_busy", {3'b0, busy}, 4'd0);

    // Button held through reset counts as a single press afterwards.
    btn_play = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    check("held_rst_wait", {1'b0, act}, {1'b0, A_IDLE});
    tick();
    check("held_rst_press", {1'b0, act}, {1'b0, A_PLAY});
    btn_play = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)   btn_feed = ~btn_feed;
      if ($urandom_range(0, 7) == 0)   btn_play = ~btn_play;
      if ($urandom_range(0, 7) == 0)   btn_pet  = ~btn_pet;
      if ($urandom_range(0, 39) == 0)  obstacle = ~obstacle;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
